// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM access arbiter.
package sram_arb_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_MEM
    } owner_e;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester and SRAM-side signals of the arbiter; slave is the arbiter view.
interface sram_access_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              mem_rd_req;
    logic              mem_wr_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    logic              freeze_if;
    logic              freeze_mem;
    logic [ADDR_W-3:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              sram_we;
    logic              sram_oe;
    logic              busy;

    modport slave (
        input  if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, sram_rdata,
        output if_rdata, if_ready, mem_rdata, mem_ready, freeze_if, freeze_mem,
               sram_addr, sram_wdata, sram_we, sram_oe, busy
    );

    modport master (
        output if_req, if_addr, mem_rd_req, mem_wr_req, mem_addr, mem_wdata, sram_rdata,
        input  if_rdata, if_ready, mem_rdata, mem_ready, freeze_if, freeze_mem,
               sram_addr, sram_wdata, sram_we, sram_oe, busy
    );

endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter with zero flag; holds at zero rather than wrapping.
module sram_wait_counter
    import sram_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/sram_access_arbiter.sv
// Arbitrates fetch and data accesses onto one fixed-latency single-port SRAM.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input logic                  clk,
    input logic                  rst,
    sram_access_arbiter_if.slave bus
);

    state_e              state_q;
    owner_e              owner_q, last_owner_q;
    logic                we_q;
    logic [ADDR_W-3:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W-1:0]   if_rdata_q, mem_rdata_q;
    logic                if_ready_q, mem_ready_q;
    logic                sram_we_q, sram_oe_q;

    logic mem_req, req_any, grant_mem, grant_we, cnt_load, cnt_zero;

    assign mem_req   = bus.mem_rd_req | bus.mem_wr_req;
    assign req_any   = mem_req | bus.if_req;
    // On contention the requester that did not go last wins.
    assign grant_mem = mem_req & (~bus.if_req | (last_owner_q == OWN_IF));
    assign grant_we  = grant_mem & bus.mem_wr_req;
    assign cnt_load  = (state_q == IDLE) & req_any;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.mem_addr[1:0]};

    sram_wait_counter u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (CNT_W'(WAIT_CYCLES - 1)),
        .dec_i      (state_q == ACCESS),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_IF;
            last_owner_q <= OWN_IF;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            if_rdata_q   <= '0;
            mem_rdata_q  <= '0;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            sram_we_q    <= 1'b0;
            sram_oe_q    <= 1'b0;
        end else begin
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_any) begin
                        owner_q   <= grant_mem ? OWN_MEM : OWN_IF;
                        addr_q    <= grant_mem ? bus.mem_addr[ADDR_W-1:2]
                                               : bus.if_addr[ADDR_W-1:2];
                        wdata_q   <= bus.mem_wdata;
                        we_q      <= grant_we;
                        sram_we_q <= grant_we;
                        sram_oe_q <= ~grant_we;
                        state_q   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_zero) begin
                        if (!we_q) begin
                            if (owner_q == OWN_MEM) mem_rdata_q <= bus.sram_rdata;
                            else                    if_rdata_q  <= bus.sram_rdata;
                        end
                        if (owner_q == OWN_MEM) mem_ready_q <= 1'b1;
                        else                    if_ready_q  <= 1'b1;
                        sram_we_q <= 1'b0;
                        sram_oe_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    last_owner_q <= owner_q;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.if_rdata   = if_rdata_q;
    assign bus.if_ready   = if_ready_q;
    assign bus.mem_rdata  = mem_rdata_q;
    assign bus.mem_ready  = mem_ready_q;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.sram_we    = sram_we_q;
    assign bus.sram_oe    = sram_oe_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.freeze_if  = bus.if_req & ~if_ready_q;
    assign bus.freeze_mem = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench: a WAIT_CYCLES=4 instance plus a WAIT_CYCLES=1 instance on one clock.
module tb_sram_access_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    sram_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    sram_access_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    sram_access_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    sram_access_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    // SRAM model: combinational read, write on clock edge; preloaded during reset.
    logic [31:0] sram_mem [0:1023];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) sram_mem[i] <= 32'h0;
            sram_mem[4] <= 32'hE3A01005;
            sram_mem[8] <= 32'hCAFEF00D;
        end else if (bus.sram_we) begin
            sram_mem[bus.sram_addr[9:0]] <= bus.sram_wdata;
        end
    end
    assign bus.sram_rdata  = sram_mem[bus.sram_addr[9:0]];
    assign bus1.sram_rdata = sram_mem[bus1.sram_addr[9:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns with the bench sitting in the DONE cycle of the access.
    task automatic wait_ready(input bit is_mem, input int exp_lat, input string tag);
        int lat;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if ((is_mem ? bus.mem_ready : bus.if_ready) === 1'b1) begin
                lat = k;
                break;
            end
        end
        check_eq(tag, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        int we_cnt;
        int mem_t[2];
        int if_t[2];
        int nm;
        int ni;
        int r1_t[3];
        int n1;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.if_req = 0;      bus.if_addr = 0;  bus.mem_rd_req = 0; bus.mem_wr_req = 0;
        bus.mem_addr = 0;    bus.mem_wdata = 0;
        bus1.if_req = 0;     bus1.if_addr = 0; bus1.mem_rd_req = 0; bus1.mem_wr_req = 0;
        bus1.mem_addr = 0;   bus1.mem_wdata = 0;

        step();
        step();
        check_eq("reset_busy", 64'(bus.busy), 64'd0);
        check_eq("reset_oe_we", 64'({bus.sram_oe, bus.sram_we}), 64'd0);
        check_eq("reset_ready", 64'({bus.if_ready, bus.mem_ready}), 64'd0);
        check_eq("reset_rdata", 64'({bus.if_rdata, bus.mem_rdata}), 64'd0);
        rst = 1'b0;

        // Single fetch
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        #1;
        check_eq("fetch_freeze_c0", 64'(bus.freeze_if), 64'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin
                check_eq("fetch_sram_addr", 64'(bus.sram_addr), 64'h4);
                check_eq("fetch_oe", 64'({bus.sram_oe, bus.sram_we}), 64'b10);
            end
            if (k < 5) begin
                check_eq("fetch_freeze_acc", 64'(bus.freeze_if), 64'd1);
                check_eq("fetch_no_ready", 64'(bus.if_ready), 64'd0);
            end else begin
                check_eq("fetch_ready_c5", 64'(bus.if_ready), 64'd1);
                check_eq("fetch_rdata", 64'(bus.if_rdata), 64'hE3A01005);
                check_eq("fetch_freeze_done", 64'(bus.freeze_if), 64'd0);
                check_eq("fetch_done_oe", 64'({bus.sram_oe, bus.sram_we}), 64'd0);
            end
        end
        bus.if_req = 1'b0;
        step();

        // Write then read back
        bus.mem_wr_req = 1'b1;
        bus.mem_addr   = 32'h400;
        bus.mem_wdata  = 32'hDEADBEEF;
        we_cnt = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (bus.sram_we === 1'b1) we_cnt++;
            if (k == 1) check_eq("wr_sram_addr", 64'(bus.sram_addr), 64'h100);
            if (k == 5) begin
                check_eq("wr_ready", 64'(bus.mem_ready), 64'd1);
                bus.mem_wr_req = 1'b0;
            end
        end
        check_eq("wr_we_cycles", 64'(we_cnt), 64'd4);
        check_eq("wr_rdata_kept", 64'(bus.mem_rdata), 64'd0);
        bus.mem_rd_req = 1'b1;
        wait_ready(1'b1, 5, "rd_latency");
        check_eq("rd_rdata", 64'(bus.mem_rdata), 64'hDEADBEEF);
        bus.mem_rd_req = 1'b0;
        step();

        // Fetch dropped mid-access still completes
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h20;
        step();
        step();
        bus.if_req = 1'b0;
        step();
        step();
        step();
        check_eq("drop_ready", 64'(bus.if_ready), 64'd1);
        check_eq("drop_rdata", 64'(bus.if_rdata), 64'hCAFEF00D);
        step();
        check_eq("drop_idle_busy", 64'(bus.busy), 64'd0);
        step();
        check_eq("drop_idle_busy2", 64'(bus.busy), 64'd0);

        // Reset in the third ACCESS cycle of a write
        bus.mem_wr_req = 1'b1;
        bus.mem_addr   = 32'h404;
        bus.mem_wdata  = 32'h12345678;
        step();
        step();
        step();
        check_eq("rstw_we_before", 64'(bus.sram_we), 64'd1);
        rst = 1'b1;
        bus.mem_wr_req = 1'b0;
        step();
        check_eq("rstw_we", 64'(bus.sram_we), 64'd0);
        check_eq("rstw_busy", 64'(bus.busy), 64'd0);
        check_eq("rstw_no_ready", 64'(bus.mem_ready), 64'd0);
        check_eq("rstw_rdata_clr", 64'(bus.mem_rdata), 64'd0);
        rst = 1'b0;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h10;
        wait_ready(1'b0, 5, "post_rst_latency");
        check_eq("post_rst_rdata", 64'(bus.if_rdata), 64'hE3A01005);
        bus.if_req = 1'b0;
        step();

        // Contention from reset: MEM, IF, MEM, IF
        bus.if_req     = 1'b1;
        bus.if_addr    = 32'h10;
        bus.mem_rd_req = 1'b1;
        bus.mem_addr   = 32'h20;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        nm = 0;
        ni = 0;
        for (int k = 1; k <= 24; k++) begin
            step();
            if (bus.mem_ready === 1'b1 && nm < 2) begin mem_t[nm] = k; nm++; end
            if (bus.if_ready === 1'b1 && ni < 2) begin if_t[ni] = k; ni++; end
        end
        check_eq("alt_counts", 64'({nm[7:0], ni[7:0]}), 64'h0202);
        if (nm == 2 && ni == 2) begin
            check_eq("alt_mem0", 64'(mem_t[0]), 64'd5);
            check_eq("alt_if0", 64'(if_t[0]), 64'd11);
            check_eq("alt_mem1", 64'(mem_t[1]), 64'd17);
            check_eq("alt_if1", 64'(if_t[1]), 64'd23);
        end
        check_eq("alt_mem_rdata", 64'(bus.mem_rdata), 64'hCAFEF00D);
        check_eq("alt_if_rdata", 64'(bus.if_rdata), 64'hE3A01005);
        bus.if_req     = 1'b0;
        bus.mem_rd_req = 1'b0;

        // WAIT_CYCLES=1: back-to-back fetches
        bus1.if_req  = 1'b1;
        bus1.if_addr = 32'h10;
        n1 = 0;
        for (int k = 1; k <= 9; k++) begin
            step();
            if (bus1.if_ready === 1'b1 && n1 < 3) begin r1_t[n1] = k; n1++; end
        end
        check_eq("w1_count", 64'(n1), 64'd3);
        if (n1 == 3) begin
            check_eq("w1_lat", 64'(r1_t[0]), 64'd2);
            check_eq("w1_per1", 64'(r1_t[1]), 64'd5);
            check_eq("w1_per2", 64'(r1_t[2]), 64'd8);
        end
        check_eq("w1_rdata", 64'(bus1.if_rdata), 64'hE3A01005);
        bus1.if_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Shares one single-port, fixed-latency SRAM between the fetch stage (instruction reads) and the memory stage (data reads and writes).
- Sequences each SRAM access through a wait-state counter.
- Returns a one-cycle ready pulse per completed access.
- Generates the freeze/stall signals that the pipeline currently ties to 0.
- Sits between the fetch/memory stages and the external SRAM model at CPU top level.

Parameters:
- ADDR_W, 32, byte-address width of requester ports.
- DATA_W, 32, data word width.
- WAIT_CYCLES, 4, SRAM access duration in cycles; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch read request; held with if_addr stable until if_ready.
- if_addr  in  ADDR_W  fetch byte address.
- if_rdata  out  DATA_W  fetched instruction word.
- if_ready  out  1  one-cycle pulse: fetch access complete, if_rdata valid.
- mem_rd_req  in  1  data read request.
- mem_wr_req  in  1  data write request.
- mem_addr  in  ADDR_W  data byte address.
- mem_wdata  in  DATA_W  write data.
- mem_rdata  out  DATA_W  read data.
- mem_ready  out  1  one-cycle pulse: data access complete.
- freeze_if  out  1  stall fetch/IF2ID.
- freeze_mem  out  1  stall memory stage and all earlier stages.
- sram_addr  out  ADDR_W-2  word address, equal to latched addr[ADDR_W-1:2].
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data; valid in the last ACCESS cycle.
- sram_we  out  1  SRAM write enable.
- sram_oe  out  1  SRAM output enable.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset values: state=IDLE; counter=0; last_owner=IF; all outputs 0, including if_rdata and mem_rdata.
- States: IDLE, ACCESS, DONE.

IDLE:
- Arbitration happens only in IDLE; there is no preemption.
- Only mem request pending: grant MEM.
- Only if_req pending: grant IF.
- Both pending: grant the owner that was not last_owner (alternation), so neither requester can starve the other.
- On grant: latch owner, addr, wdata and we; set counter=WAIT_CYCLES-1; go to ACCESS.
- we = mem_wr_req for a MEM grant, 0 for an IF grant. If mem_rd_req and mem_wr_req are both high, treat the access as a write.
- No request pending: stay in IDLE.

ACCESS:
- sram_addr and sram_wdata are driven from latched values.
- sram_we = latched we; sram_oe = ~latched we.
- Counter decrements each cycle.
- Last cycle (counter==0): for a read, capture sram_rdata into the owner's rdata register; then go to DONE.
- ACCESS lasts exactly WAIT_CYCLES cycles.

DONE:
- The owner's ready output is high for exactly this cycle.
- sram_we=sram_oe=0.
- last_owner<=owner; go to IDLE.

Latency and hold rules:
- Latency: request sampled in IDLE at cycle 0, ready high at cycle WAIT_CYCLES+1.
- Minimum period per access is WAIT_CYCLES+2 cycles.
- A request still high in the IDLE cycle after DONE is a new access.
- rdata registers hold their value until the next read completion for the same owner. Writes never change mem_rdata.

Freeze outputs (combinational):
- freeze_if = if_req & ~if_ready.
- freeze_mem = (mem_rd_req|mem_wr_req) & ~mem_ready.

Boundary conditions:
- Request dropped mid-access (e.g. fetch flushed on a branch): the access still completes; ready still pulses; for reads, rdata is still updated.
- WAIT_CYCLES=1: ACCESS lasts one cycle; total latency is 2.
- Reset asserted mid-ACCESS: at that edge, state returns to IDLE and sram_we/sram_oe go to 0. No ready pulse is produced.

Decomposition:
- Package sram_arb_pkg holds:
  - state enum {IDLE, ACCESS, DONE};
  - owner enum {OWN_IF, OWN_MEM};
  - constant CNT_W = 4.
- One sub-module: sram_wait_counter, a loadable down-counter with a zero flag.

Test Plan:
- WAIT_CYCLES=4, rst high 2 cycles, then if_req=1, if_addr=0x10, SRAM word 4=0xE3A01005 → if_ready pulses at cycle 5 after request, if_rdata=0xE3A01005, sram_addr=4, freeze_if high cycles 0-4.
- mem_wr_req=1, mem_addr=0x400, mem_wdata=0xDEADBEEF → sram_we high exactly 4 cycles with sram_addr=0x100; then mem_rd_req to 0x400 → mem_rdata=0xDEADBEEF; mem_rdata unchanged after the write alone.
- if_req and mem_rd_req both high continuously from reset (last_owner=IF) → grant order MEM, IF, MEM, IF; ready pulses alternate every 6 cycles.
- if_req dropped during ACCESS cycle 2 → if_ready still pulses; next IDLE with no request keeps busy=0.
- rst asserted during ACCESS cycle 3 of a write → next cycle: sram_we=0, busy=0, no ready pulse; a subsequent if_req completes normally.
- Rebuild with WAIT_CYCLES=1, back-to-back if_req → if_ready every 3 cycles, latency 2.
